trigger_ctl_avmm_master: RTL and testbench

Avalon-MM initiator that drives the trigger-control PIO slaves (rx/tx trigger_ctl) from a simple command/response stream.
- Issues full writes (addr 0), bit-set writes (addr 4) and bit-clear writes (addr 5).
- Issues reads of the input port (addr 0) and polls it until a masked match or a timeout.
- Generates timed set-then-clear pulses for arm/fire bits.
- Sits between the trigger sequencer logic and the PIO slave; no software round-trip is needed for trigger timing.

---
 rtl/trigger_ctl_pkg.sv | 30 +++
 rtl/trigger_ctl_avmm_master.sv | 194 +++++++++++++++++++
 tb/tb_trigger_ctl_avmm_master.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_ctl_pkg.sv
// Shared encodings for the trigger-control Avalon-MM initiator:
// command ops, response status, PIO register offsets and FSM states.
package trigger_ctl_pkg;

   localparam logic [2:0] OP_WRITE = 3'd0;
   localparam logic [2:0] OP_SET   = 3'd1;
   localparam logic [2:0] OP_CLEAR = 3'd2;
   localparam logic [2:0] OP_READ  = 3'd3;
   localparam logic [2:0] OP_POLL  = 3'd4;
   localparam logic [2:0] OP_PULSE = 3'd5;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_TIMEOUT = 2'd1;
   localparam logic [1:0] ST_ILLEGAL = 2'd2;

   localparam int unsigned REG_DATA  = 0;
   localparam int unsigned REG_SET   = 4;
   localparam int unsigned REG_CLEAR = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_WAIT,
      S_HOLD,
      S_CLR,
      S_RESP
   } state_e;

endpackage

// File: rtl/trigger_ctl_avmm_master.sv
// Avalon-MM initiator driving a trigger-control PIO slave from a
// command/response stream: writes, set/clear, reads, polls and pulses.
module trigger_ctl_avmm_master
   import trigger_ctl_pkg::*;
#(
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 32,
   parameter int PORT_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [PORT_W-1:0]    cmd_data,
   input  logic [PORT_W-1:0]    cmd_mask,
   input  logic [TIMEOUT_W-1:0] cmd_timeout,
   output logic                 rsp_valid,
   output logic [PORT_W-1:0]    rsp_data,
   output logic [1:0]           rsp_status,
   output logic [ADDR_W-1:0]    avm_address,
   output logic                 avm_chipselect,
   output logic                 avm_write_n,
   output logic [DATA_W-1:0]    avm_writedata,
   input  logic [DATA_W-1:0]    avm_readdata
);

   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   state_e               state;
   logic [2:0]           op_q;
   logic [PORT_W-1:0]    data_q;
   logic [PORT_W-1:0]    mask_q;
   logic [TIMEOUT_W-1:0] tmo_q;
   logic [TIMEOUT_W-1:0] cnt;
   logic [LAT_W-1:0]     lat_cnt;

   logic [PORT_W-1:0]    rd_val;
   logic                 rd_match;
   logic                 unused_rd_hi;

   assign rd_val       = avm_readdata[PORT_W-1:0];
   assign rd_match     = (rd_val & mask_q) == (data_q & mask_q);
   assign unused_rd_hi = ^avm_readdata[DATA_W-1:PORT_W];

   function automatic logic [TIMEOUT_W-1:0] sat_inc(
      input logic [TIMEOUT_W-1:0] v
   );
      return (v == '1) ? v : v + 1'b1;
   endfunction

   function automatic logic [ADDR_W-1:0] wr_addr(input logic [2:0] op);
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(REG_DATA);
      if (op == OP_SET || op == OP_PULSE) a = ADDR_W'(REG_SET);
      if (op == OP_CLEAR) a = ADDR_W'(REG_CLEAR);
      return a;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         cmd_ready      <= 1'b0;
         op_q           <= '0;
         data_q         <= '0;
         mask_q         <= '0;
         tmo_q          <= '0;
         cnt            <= '0;
         lat_cnt        <= '0;
         rsp_valid      <= 1'b0;
         rsp_data       <= '0;
         rsp_status     <= ST_OK;
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  op_q      <= cmd_op;
                  data_q    <= cmd_data;
                  mask_q    <= cmd_mask;
                  tmo_q     <= cmd_timeout;
                  cnt       <= '0;
                  unique case (cmd_op)
                     OP_WRITE, OP_SET, OP_CLEAR, OP_PULSE: begin
                        state          <= S_WR;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= 1'b0;
                        avm_address    <= wr_addr(cmd_op);
                        avm_writedata  <= DATA_W'(cmd_data);
                     end
                     OP_READ, OP_POLL: begin
                        state          <= S_RD;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_W'(REG_DATA);
                     end
                     default: begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_ILLEGAL;
                        rsp_data   <= cmd_data;
                     end
                  endcase
               end
            end
            S_WR: begin
               avm_chipselect <= 1'b0;
               avm_write_n    <= 1'b1;
               avm_address    <= '0;
               avm_writedata  <= '0;
               if (op_q == OP_PULSE && tmo_q != '0) begin
                  state <= S_HOLD;
                  cnt   <= tmo_q;
               end else if (op_q == OP_PULSE) begin
                  state          <= S_CLR;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_address    <= ADDR_W'(REG_CLEAR);
                  avm_writedata  <= DATA_W'(data_q);
               end else begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_OK;
                  rsp_data   <= data_q;
               end
            end
            S_HOLD: begin
               // cnt counts down the remaining hold cycles
               if (cnt <= 1) begin
                  state          <= S_CLR;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  avm_address    <= ADDR_W'(REG_CLEAR);
                  avm_writedata  <= DATA_W'(data_q);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_CLR: begin
               avm_chipselect <= 1'b0;
               avm_write_n    <= 1'b1;
               avm_address    <= '0;
               avm_writedata  <= '0;
               state          <= S_RESP;
               rsp_valid      <= 1'b1;
               rsp_status     <= ST_OK;
               rsp_data       <= data_q;
            end
            S_RD: begin
               avm_chipselect <= 1'b0;
               avm_address    <= '0;
               cnt            <= sat_inc(cnt);
               lat_cnt        <= LAT_W'(READ_LATENCY - 1);
               state          <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               cnt <= sat_inc(cnt);
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - 1'b1;
               end else if (op_q == OP_READ || rd_match) begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_OK;
                  rsp_data   <= rd_val;
               end else if (cnt >= tmo_q) begin
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_TIMEOUT;
                  rsp_data   <= rd_val;
               end else begin
                  state          <= S_RD;
                  avm_chipselect <= 1'b1;
                  avm_address    <= ADDR_W'(REG_DATA);
               end
            end
            S_RESP: begin
               rsp_valid  <= 1'b0;
               rsp_data   <= '0;
               rsp_status <= ST_OK;
               cmd_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_ctl_avmm_master.sv
// Bench for trigger_ctl_avmm_master: PIO slave model, response
// scoreboard, vector table and hand-written multi-cycle sequences.
module tb_trigger_ctl_avmm_master;
   import trigger_ctl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [7:0]  cmd_data = '0;
   logic [7:0]  cmd_mask = '0;
   logic [15:0] cmd_timeout = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_status;
   logic [2:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = '0;

   always #5 clk = ~clk;

   trigger_ctl_avmm_master #(
      .ADDR_W(3), .DATA_W(32), .PORT_W(8),
      .READ_LATENCY(1), .TIMEOUT_W(16)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .cmd_timeout(cmd_timeout),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_status(rsp_status),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata)
   );

   // PIO slave model: registered readdata, junk in the upper bits
   logic [7:0] in_port = '0;
   logic [7:0] data_out = '0;
   always @(posedge clk) begin
      if (avm_chipselect && !avm_write_n) begin
         case (avm_address)
            3'd0: data_out <= avm_writedata[7:0];
            3'd4: data_out <= data_out | avm_writedata[7:0];
            3'd5: data_out <= data_out & ~avm_writedata[7:0];
            default: ;
         endcase
      end
      if (avm_chipselect && avm_write_n)
         avm_readdata <= {24'h5A5A5A, in_port};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         tacc;
      int         lat;
      logic [7:0] data;
      bit         chkd;
      logic [1:0] st;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int         c;
      logic [2:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t wr_log[$];
   int nrd = 0;
   int hi_cnt = 0;
   logic [7:0] hi_mask = '0;

   always @(negedge clk) begin
      if (avm_chipselect && !avm_write_n)
         wr_log.push_back('{cyc, avm_address, avm_writedata});
      if (avm_chipselect && avm_write_n) nrd++;
      if ((data_out & hi_mask) != 0) hi_cnt++;
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_status", 32'(rsp_status), 32'(e.st));
            if (e.chkd) check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_latency", 32'(cyc - e.tacc), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] d,
                        input logic [7:0] m, input logic [15:0] t,
                        input bit push, input exp_t e,
                        output int tacc);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_data    = d;
      cmd_mask    = m;
      cmd_timeout = t;
      tacc        = cyc;
      e.tacc      = cyc;
      if (push) sb.push_back(e);
      @(negedge clk);
      cmd_valid   = 1'b0;
      cmd_op      = 3'd7;
      cmd_data    = 8'hXX;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(sb.size() == 0 && cmd_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done"}, 32'(n < 300), 32'd1);
   endtask

   typedef struct {
      logic [7:0]  inp;
      logic [2:0]  op;
      logic [7:0]  d;
      logic [7:0]  m;
      logic [15:0] t;
      int          lat;
      logic [1:0]  st;
      logic [7:0]  rd;
      bit          chkd;
      int          nwr;
      logic [2:0]  addr;
      int          nrd;
      logic [7:0]  dout;
   } vec_t;
   vec_t vt[10];

   initial begin : main
      int tacc;
      exp_t e;

      vt[0] = '{8'h00, OP_WRITE, 8'hA5, 8'h00, 16'd0, 2, ST_OK,
                8'hA5, 1'b1, 1, 3'd0, 0, 8'hA5};
      vt[1] = '{8'h00, OP_WRITE, 8'h00, 8'h00, 16'd0, 2, ST_OK,
                8'h00, 1'b1, 1, 3'd0, 0, 8'h00};
      vt[2] = '{8'h00, OP_SET, 8'h01, 8'h00, 16'd0, 2, ST_OK,
                8'h01, 1'b1, 1, 3'd4, 0, 8'h01};
      vt[3] = '{8'h00, OP_CLEAR, 8'h01, 8'h00, 16'd0, 2, ST_OK,
                8'h01, 1'b1, 1, 3'd5, 0, 8'h00};
      vt[4] = '{8'h3C, OP_READ, 8'h00, 8'h00, 16'd0, 3, ST_OK,
                8'h3C, 1'b1, 0, 3'd0, 1, 8'h00};
      vt[5] = '{8'h00, 3'd6, 8'h11, 8'h00, 16'd0, 1, ST_ILLEGAL,
                8'h00, 1'b0, 0, 3'd0, 0, 8'h00};
      vt[6] = '{8'h00, 3'd7, 8'h22, 8'h00, 16'd0, 1, ST_ILLEGAL,
                8'h00, 1'b0, 0, 3'd0, 0, 8'h00};
      vt[7] = '{8'h55, OP_POLL, 8'hAA, 8'h00, 16'd5, 3, ST_OK,
                8'h55, 1'b1, 0, 3'd0, 1, 8'h00};
      vt[8] = '{8'h55, OP_POLL, 8'hAA, 8'hFF, 16'd0, 3, ST_TIMEOUT,
                8'h55, 1'b1, 0, 3'd0, 1, 8'h00};
      vt[9] = '{8'hF5, OP_POLL, 8'h05, 8'h0F, 16'd9, 3, ST_OK,
                8'hF5, 1'b1, 0, 3'd0, 1, 8'h00};

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp", {rsp_valid, rsp_status, rsp_data}, 32'd0);
      check("rst_bus", {avm_chipselect, avm_write_n, avm_address},
            32'b0_1_000);
      check("rst_wdata", avm_writedata, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         in_port = vt[i].inp;
         wr_log.delete();
         nrd = 0;
         e = '{0, vt[i].lat, vt[i].rd, vt[i].chkd, vt[i].st};
         issue(vt[i].op, vt[i].d, vt[i].m, vt[i].t, 1'b1, e, tacc);
         wait_done($sformatf("v%0d", i));
         check($sformatf("v%0d_nwr", i), 32'(wr_log.size()),
               32'(vt[i].nwr));
         if (wr_log.size() > 0) begin
            check($sformatf("v%0d_addr", i), 32'(wr_log[0].a),
                  32'(vt[i].addr));
            check($sformatf("v%0d_wdata", i), wr_log[0].d,
                  32'(vt[i].d));
            check($sformatf("v%0d_wcyc", i), 32'(wr_log[0].c),
                  32'(tacc + 1));
         end
         check($sformatf("v%0d_nrd", i), 32'(nrd), 32'(vt[i].nrd));
         check($sformatf("v%0d_dout", i), 32'(data_out),
               32'(vt[i].dout));
      end

      // poll that never matches: reads at T+1,3,..,21, gives up at T+23
      in_port = 8'h00;
      wr_log.delete();
      nrd = 0;
      e = '{0, 23, 8'h00, 1'b1, ST_TIMEOUT};
      issue(OP_POLL, 8'h08, 8'h08, 16'd20, 1'b1, e, tacc);
      wait_done("poll_to");
      check("poll_to_nrd", 32'(nrd), 32'd11);
      check("poll_to_nwr", 32'(wr_log.size()), 32'd0);

      // bit3 rises at T+9: the read issued at T+9 sees it, RESP at T+11
      e = '{0, 11, 8'h08, 1'b1, ST_OK};
      issue(OP_POLL, 8'h08, 8'h08, 16'd20, 1'b1, e, tacc);
      repeat (8) @(negedge clk);
      in_port = 8'h08;
      wait_done("poll_hit");
      in_port = 8'h00;

      // pulse with 3 hold cycles
      wr_log.delete();
      hi_mask = 8'h02;
      hi_cnt = 0;
      e = '{0, 6, 8'h02, 1'b1, ST_OK};
      issue(OP_PULSE, 8'h02, 8'h00, 16'd3, 1'b1, e, tacc);
      wait_done("pulse3");
      check("pulse3_nwr", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check("pulse3_set", {wr_log[0].a, 32'(wr_log[0].c - tacc)},
               {3'd4, 32'd1});
         check("pulse3_clr", {wr_log[1].a, 32'(wr_log[1].c - tacc)},
               {3'd5, 32'd5});
      end
      check("pulse3_hi", 32'(hi_cnt), 32'd4);
      check("pulse3_dout", 32'(data_out), 32'd0);

      // pulse with no hold
      wr_log.delete();
      hi_mask = 8'h04;
      hi_cnt = 0;
      e = '{0, 3, 8'h04, 1'b1, ST_OK};
      issue(OP_PULSE, 8'h04, 8'h00, 16'd0, 1'b1, e, tacc);
      wait_done("pulse0");
      check("pulse0_nwr", 32'(wr_log.size()), 32'd2);
      check("pulse0_hi", 32'(hi_cnt), 32'd1);

      // reset the cycle after the SET write of a pulse
      wr_log.delete();
      e = '{0, 0, 8'h00, 1'b0, ST_OK};
      issue(OP_PULSE, 8'h02, 8'h00, 16'd3, 1'b0, e, tacc);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_bus", {avm_chipselect, avm_write_n, avm_address},
            32'b0_1_000);
      check("mid_rst_rsp", {cmd_ready, rsp_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_rst_nwr", 32'(wr_log.size()), 32'd1);
      check("mid_rst_dout", 32'(data_out), 32'h02);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);

      // the owner reissues the CLEAR
      e = '{0, 2, 8'h02, 1'b1, ST_OK};
      issue(OP_CLEAR, 8'h02, 8'h00, 16'd0, 1'b1, e, tacc);
      wait_done("reclear");
      check("reclear_dout", 32'(data_out), 32'd0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
